// File: rtl/xbar_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// xbar_rr_arbiter_if
// Handshake bundle between one crossbar output port and its arbiter.
//
// Parameters:
//   S_DATA_COUNT  number of requesting masters (1..32)
//   IDX_WIDTH     width of the binary grant index (min 1)
//
// Signals (direction named from the arbiter's point of view):
//   req_i          [S_DATA_COUNT]  per-master request for this output
//   m_ready_i      1               tready of this output
//   m_last_i       1               tlast of the currently granted master
//   grant_o        [S_DATA_COUNT]  one-hot grant, zero when idle
//   grant_idx_o    [IDX_WIDTH]     binary index of the granted master
//   grant_valid_o  1               a grant is active
//
// Modports:
//   master  crossbar / stimulus side (drives requests, reads grants)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface xbar_rr_arbiter_if #(
  parameter int S_DATA_COUNT = 2
);
  localparam int IDX_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

  logic [S_DATA_COUNT-1:0] req_i;
  logic                    m_ready_i;
  logic                    m_last_i;
  logic [S_DATA_COUNT-1:0] grant_o;
  logic [IDX_WIDTH-1:0]    grant_idx_o;
  logic                    grant_valid_o;

  modport master (
    output req_i,
    output m_ready_i,
    output m_last_i,
    input  grant_o,
    input  grant_idx_o,
    input  grant_valid_o
  );

  modport slave (
    input  req_i,
    input  m_ready_i,
    input  m_last_i,
    output grant_o,
    output grant_idx_o,
    output grant_valid_o
  );
endinterface

// File: rtl/xbar_rr_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_rr_arbiter
// Per-output round-robin arbiter for the stream crossbar. Picks one master
// from the request column, holds the grant until release, then leaves one
// IDLE cycle before re-arbitrating. The round-robin pointer moves only on
// release, to the master after the one just served.
//
// Configuration macro: XBAR_ARB_PKT_LOCK_EN
//   defined   : grant held for a whole packet, released on an accepted
//               beat with m_last_i high
//   undefined : grant released on every accepted beat (m_last_i unused)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   arb_if   xbar_rr_arbiter_if.slave (req/ready/last in, grant out)
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module xbar_rr_arbiter #(
  parameter int S_DATA_COUNT = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  xbar_rr_arbiter_if.slave     arb_if
);

  localparam int IDX_WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [S_DATA_COUNT-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;

  logic                    beat_acc_s;
  logic                    release_s;
  logic [IDX_WIDTH:0]      pick_s;
  logic                    pick_found_s;
  logic [IDX_WIDTH-1:0]    pick_idx_s;
  logic [IDX_WIDTH-1:0]    next_ptr_s;

  // Round-robin search: first set request starting at ptr and wrapping.
  // Returns {found, index}.
  function automatic logic [IDX_WIDTH:0] rr_pick(
    input logic [S_DATA_COUNT-1:0] req,
    input logic [IDX_WIDTH-1:0]    ptr
  );
    logic                 found;
    logic [IDX_WIDTH-1:0] idx;
    int                   cand;
    found = 1'b0;
    idx   = {IDX_WIDTH{1'b0}};
    for (int k = 0; k < S_DATA_COUNT; k++) begin
      cand = int'(ptr) + k;
      if (cand >= S_DATA_COUNT) begin
        cand = cand - S_DATA_COUNT;
      end else begin
        cand = cand;
      end
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = IDX_WIDTH'(cand);
      end else begin
        found = found;
      end
    end
    return {found, idx};
  endfunction

  assign pick_s       = rr_pick(arb_if.req_i, ptr_q);
  assign pick_found_s = pick_s[IDX_WIDTH];
  assign pick_idx_s   = pick_s[IDX_WIDTH-1:0];

  // A beat moves only while the granted master still requests this output.
  assign beat_acc_s = grant_valid_q & arb_if.req_i[grant_idx_q] & arb_if.m_ready_i;

`ifdef XBAR_ARB_PKT_LOCK_EN
  assign release_s = beat_acc_s & arb_if.m_last_i;
`else
  // Beat-level mode: tlast is irrelevant, keep it as a deliberate sink.
  logic unused_last_s;
  assign unused_last_s = arb_if.m_last_i;
  assign release_s     = beat_acc_s;
`endif

  // Pointer after release: master following the one just served, wrapping.
  assign next_ptr_s = (grant_idx_q == IDX_WIDTH'(S_DATA_COUNT - 1))
                      ? {IDX_WIDTH{1'b0}}
                      : grant_idx_q + IDX_WIDTH'(1);

  // Next-state logic for arbitration FSM, grant and pointer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d       = ST_LOCKED;
          grant_d       = S_DATA_COUNT'(1'b1) << pick_idx_s;
          grant_idx_d   = pick_idx_s;
          grant_valid_d = 1'b1;
        end else begin
          state_d       = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (release_s) begin
          state_d       = ST_IDLE;
          grant_d       = {S_DATA_COUNT{1'b0}};
          grant_valid_d = 1'b0;
          ptr_d         = next_ptr_s;
        end else begin
          state_d       = ST_LOCKED;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = {S_DATA_COUNT{1'b0}};
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      grant_q       <= {S_DATA_COUNT{1'b0}};
      grant_idx_q   <= {IDX_WIDTH{1'b0}};
      grant_valid_q <= 1'b0;
      ptr_q         <= {IDX_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
    end
  end

  assign arb_if.grant_o       = grant_q;
  assign arb_if.grant_idx_o   = grant_idx_q;
  assign arb_if.grant_valid_o = grant_valid_q;

`ifndef SYNTHESIS
  xbar_rr_arbiter_chk #(
    .S_DATA_COUNT (S_DATA_COUNT),
    .IDX_WIDTH    (IDX_WIDTH)
  ) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .grant_i       (grant_q),
    .grant_idx_i   (grant_idx_q),
    .grant_valid_i (grant_valid_q)
  );
`endif

endmodule

// ---------------------------------------------------------------------------
// xbar_rr_arbiter_chk
// Simulation-only invariants on the arbiter outputs.
// Ports: clk_i, rst_i, grant_i, grant_idx_i, grant_valid_i (all inputs).
// ---------------------------------------------------------------------------
module xbar_rr_arbiter_chk #(
  parameter int S_DATA_COUNT = 2,
  parameter int IDX_WIDTH    = 1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  input logic [S_DATA_COUNT-1:0] grant_i,
  input logic [IDX_WIDTH-1:0]    grant_idx_i,
  input logic                    grant_valid_i
);

  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(grant_i))
    else $error("arbiter: grant_o has more than one bit set");

  a_valid_is_or: assert property (@(posedge clk_i) disable iff (rst_i)
    grant_valid_i == (|grant_i))
    else $error("arbiter: grant_valid_o disagrees with grant_o");

  a_idx_matches: assert property (@(posedge clk_i) disable iff (rst_i)
    grant_valid_i |-> (grant_i == (S_DATA_COUNT'(1'b1) << grant_idx_i)))
    else $error("arbiter: grant_o does not match grant_idx_o");

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbar_rr_arbiter
// Self-checking bench for xbar_rr_arbiter with S_DATA_COUNT=3. A behavioural
// model (integer granted master, integer pointer) predicts the outputs every
// cycle; directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_xbar_rr_arbiter;

  localparam int N  = 3;
  localparam int IW = 2;
`ifdef XBAR_ARB_PKT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  xbar_rr_arbiter_if #(.S_DATA_COUNT(N)) arb_if ();

  xbar_rr_arbiter #(.S_DATA_COUNT(N)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .arb_if (arb_if)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_gnt;     // granted master, -1 when idle
  int m_idx;     // last granted index
  int m_ptr;     // round-robin start point
  int m_beats;   // beats accepted so far in current grant
  int pkt_len;   // beats per packet used to drive m_last_i

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit found;
    int j;
    if (rst_i) begin
      m_gnt = -1; m_idx = 0; m_ptr = 0; m_beats = 0;
    end else if (m_gnt < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && arb_if.req_i[j]) begin
          found = 1'b1; m_gnt = j; m_idx = j; m_beats = 0;
        end
      end
    end else if (arb_if.req_i[m_gnt] && arb_if.m_ready_i) begin
      if (!LOCK || arb_if.m_last_i) begin
        m_ptr = (m_gnt + 1) % N;
        m_gnt = -1;
      end else begin
        m_beats++;
      end
    end
  endtask

  // One clock: update model at the edge, compare outputs just after it,
  // then refresh m_last_i so the packet ends after pkt_len beats.
  task automatic step();
    logic [31:0] exp_g;
    @(posedge clk_i);
    model_update();
    #1;
    exp_g = (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0;
    check_val("grant_o", 32'(arb_if.grant_o), exp_g);
    check_val("grant_idx_o", 32'(arb_if.grant_idx_o), 32'(m_idx));
    check_val("grant_valid_o", 32'(arb_if.grant_valid_o), (m_gnt >= 0) ? 32'd1 : 32'd0);
    arb_if.m_last_i = (m_gnt >= 0) && (m_beats == pkt_len - 1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int order_q[$];
  logic prev_valid;

  initial begin
    rst_i            = 1'b1;
    arb_if.req_i     = 3'b000;
    arb_if.m_ready_i = 1'b0;
    arb_if.m_last_i  = 1'b0;
    pkt_len = 1;
    m_gnt = -1; m_idx = 0; m_ptr = 0; m_beats = 0;
    steps(2);
    check_val("reset_grant", 32'(arb_if.grant_o), 32'd0);
    check_val("reset_valid", 32'(arb_if.grant_valid_o), 32'd0);
    rst_i = 1'b0;

    // Single requester, 4-beat packet
    pkt_len = 4;
    arb_if.req_i = 3'b010; arb_if.m_ready_i = 1'b1;
    step();
    check_val("single_grant", 32'(arb_if.grant_o), 32'b010);
    check_val("single_idx", 32'(arb_if.grant_idx_o), 32'd1);
    steps(6);
    arb_if.req_i = 3'b000;
    steps(2);

    // Fairness: all request, 2-beat packets; record grant start order
    pkt_len = 2;
    rst_i = 1'b1; step(); rst_i = 1'b0;
    arb_if.req_i = 3'b111; arb_if.m_ready_i = 1'b1;
    prev_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (arb_if.grant_valid_o && !prev_valid) order_q.push_back(int'(arb_if.grant_idx_o));
      prev_valid = arb_if.grant_valid_o;
    end
    check_val("rr_count", 32'(order_q.size()), LOCK ? 32'd4 : 32'd6);
    check_val("rr_order0", 32'(order_q[0]), 32'd0);
    check_val("rr_order1", 32'(order_q[1]), 32'd1);
    check_val("rr_order2", 32'(order_q[2]), 32'd2);
    check_val("rr_order3", 32'(order_q[3]), 32'd0);

    // Lock under contention: master 0 stalled, others join
    rst_i = 1'b1; step(); rst_i = 1'b0;
    pkt_len = 3;
    arb_if.req_i = 3'b001; arb_if.m_ready_i = 1'b0;
    step();
    arb_if.req_i = 3'b111;
    steps(5);
    check_val("lock_hold", 32'(arb_if.grant_o), 32'b001);
    arb_if.m_ready_i = 1'b1;
    steps(8);

    // Valid gap: master 2 granted, drops req while others request
    rst_i = 1'b1; step(); rst_i = 1'b0;
    pkt_len = 3;
    arb_if.req_i = 3'b100; arb_if.m_ready_i = 1'b1;
    step();
    arb_if.req_i = 3'b011;
    steps(3);
    check_val("gap_hold", 32'(arb_if.grant_o), 32'b100);
    arb_if.req_i = 3'b111;
    steps(6);

    // Reset mid-packet on master 1
    rst_i = 1'b1; step(); rst_i = 1'b0;
    pkt_len = 4;
    arb_if.req_i = 3'b010; arb_if.m_ready_i = 1'b0;
    steps(2);
    arb_if.req_i = 3'b011;
    rst_i = 1'b1;
    step();
    check_val("rst_mid_grant", 32'(arb_if.grant_o), 32'd0);
    check_val("rst_mid_valid", 32'(arb_if.grant_valid_o), 32'd0);
    rst_i = 1'b0;
    step();
    check_val("rst_mid_next", 32'(arb_if.grant_o), 32'b001);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      arb_if.req_i     = 3'($urandom_range(0, 7));
      arb_if.m_ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) pkt_len = $urandom_range(1, 4);
      rst_i = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xbar_rr_arbiter.md
Name: xbar_rr_arbiter

Overview:
- Per-output arbiter for the stream crossbar. One instance per slave port (M_DATA_COUNT instances total).
- Input is that slave's request column from the request generator: bit j = master j is valid and its dest equals this slave.
- Picks one master by round-robin, holds the grant for the whole packet (until the tlast beat is accepted), then re-arbitrates.
- grant_o / grant_idx_o drive this slave's data mux and the ready fan-back to the masters.

Parameters:
- S_DATA_COUNT, 2, number of master (requester) ports; legal range 1..32.
- IDX_WIDTH (localparam), $clog2(S_DATA_COUNT) with a minimum of 1, width of the grant index.

Ports:
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  S_DATA_COUNT  request vector for this slave; bit j = s_valid_i[j] & (s_dest_i[j] == this slave).
- m_ready_i  input  1  tready from this slave.
- m_last_i  input  1  tlast of the currently granted master (muxed by grant_idx_o outside this block).
- grant_o  output  S_DATA_COUNT  one-hot grant; all zero when idle.
- grant_idx_o  output  IDX_WIDTH  binary index of the granted master; holds its last value when idle.
- grant_valid_o  output  1  high when a grant is active (OR of grant_o).

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, grant_o=0, grant_idx_o=0, grant_valid_o=0, rr pointer=0.
  - Reset dominates every other event, including mid-packet; the packet in flight is abandoned.
- Accepted beat (beat_acc): grant_valid_o & req_i[grant_idx_o] & m_ready_i.
- State IDLE:
  - If req_i != 0 at the edge, select the first set bit searching ptr, ptr+1, ..., S_DATA_COUNT-1, 0, ..., ptr-1.
  - Register the winner into grant_o / grant_idx_o, set grant_valid_o=1, move to LOCKED.
  - If req_i == 0, stay IDLE.
  - Latency: request seen at edge N, grant visible after edge N (registered outputs, one cycle).
- State LOCKED:
  - Grant is held regardless of other requests.
  - If the granted master drops req (a valid gap or a dest change mid-packet), the grant is still held. No timeout.
  - If beat_acc & m_last_i at the edge: grant_o=0, grant_valid_o=0, ptr=(grant_idx_o+1) mod S_DATA_COUNT, go to IDLE.
  - Otherwise stay LOCKED.
- Re-arbitration bubble: after a release there is exactly one IDLE cycle, so back-to-back packets to the same slave cost one cycle each.
- Pointer wrap: at grant_idx_o = S_DATA_COUNT-1 the pointer wraps to 0.
- Pointer stability: the pointer changes only on release.
- S_DATA_COUNT=1: the pointer is always 0 and the grant goes to master 0 whenever req_i[0] is high.
- m_last_i and m_ready_i are ignored in IDLE.
- Outputs have no combinational path from inputs.
- Assertions (sim only):
  - grant_o is one-hot or zero.
  - grant_valid_o == |grant_o.
  - grant_o == (1 << grant_idx_o) whenever grant_valid_o is high.

Optional Feature:
- Macro: XBAR_ARB_PKT_LOCK_EN.
- Defined: packet locking exactly as described above; release only on a beat accepted with m_last_i high.
- Not defined: beat-level round-robin.
  - Release happens on every beat_acc, whatever m_last_i is, with the same pointer update and the same one-cycle IDLE bubble.
  - m_last_i is unused (kept on the port list so instantiation does not change).
- Default build defines the macro; crossbar integration requires it whenever packets are longer than one beat.

Test Plan:
- Single requester:
  - S_DATA_COUNT=3, req_i=3'b010 from cycle 1 -> grant_o=3'b010, grant_idx_o=1 after the next edge.
  - 4-beat packet with m_ready_i=1, last on beat 4 -> grant drops the cycle after beat 4; ptr=2.
- Round-robin fairness:
  - req_i=3'b111 held constantly, 2-beat packets, ready=1 -> grant order 0,1,2,0,...
  - Each grant lasts 2 cycles with 1 idle cycle between grants.
- Lock under contention:
  - Master 0 granted mid-packet, req_i goes 3'b001 -> 3'b111 with m_ready_i=0 for 5 cycles -> grant stays 3'b001 the whole time.
  - The first accepted last beat releases; the next grant goes to master 1.
- Valid gap: granted master 2 deasserts req for 3 cycles mid-packet -> grant_o stays 3'b100; the other requesters are not granted.
- Reset mid-packet: rst_i pulsed for 1 cycle while LOCKED on master 1 -> the next cycle shows grant_o=0, grant_valid_o=0, ptr=0; with req_i=3'b011 the next grant is master 0.
- Macro off: req_i=3'b011, m_last_i=0, ready=1 -> grants alternate 0,1,0,1 every 2 cycles (one-beat grant plus one-cycle bubble), ignoring last.
